ycr1_reset_seq_ctrl: RTL and testbench

Reset sequencer that sits directly upstream of the reset-sync and qualifier-adapter cells.
It generates the synchronous system and core reset requests (sys_rst_n_sync, core_rst_n_sync) that those cells buffer and distribute.
It handles power-on stretching, staggered release, software, watchdog and debug reset requests, and a bus-drain handshake with timeout.
It records the cause of the last reset for software readback.

---
 rtl/ycr1_reset_seq_ctrl.sv | 89 ++++++++
 tb/tb_ycr1_reset_seq_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/ycr1_reset_seq_ctrl.sv
// ycr1_reset_seq_ctrl: reset sequencer with POR stretch, staggered release, drain handshake and cause capture
module ycr1_reset_seq_ctrl #(
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int DRAIN_TIMEOUT  = 64
) (
  input  logic       clk,
  input  logic       rst_n_mux,
  input  logic       test_mode,
  input  logic       test_rst_n,
  input  logic       sys_rst_req,
  input  logic       wdt_rst_req,
  input  logic       dbg_rst_req,
  input  logic       drain_ack,
  output logic       drain_req,
  output logic       sys_rst_n_sync,
  output logic       core_rst_n_sync,
  output logic [1:0] rst_cause,
  output logic       drain_timeout,
  output logic       seq_busy
);
  localparam int MAX_HS = HOLD_CYCLES > STAGGER_CYCLES ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int MAX_C  = MAX_HS > DRAIN_TIMEOUT ? MAX_HS : DRAIN_TIMEOUT;
  localparam int CW     = $clog2(MAX_C) + 1;
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LAST  = CW'(STAGGER_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    POR_HOLD, STAGGER, RUN, DRAIN, ASSERT, CORE_HOLD
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            sys_q, core_q;
  logic            sys_nxt, core_nxt, drain_nxt, busy_nxt, timeout_nxt;
  logic [1:0]      cause_nxt;

  always_ff @(posedge clk or negedge rst_n_mux) begin
    if (!rst_n_mux) begin
      state         <= POR_HOLD;
      cnt           <= '0;
      sys_q         <= 1'b0;
      core_q        <= 1'b0;
      drain_req     <= 1'b0;
      rst_cause     <= 2'b00;
      drain_timeout <= 1'b0;
      seq_busy      <= 1'b1;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      sys_q         <= sys_nxt;
      core_q        <= core_nxt;
      drain_req     <= drain_nxt;
      rst_cause     <= cause_nxt;
      drain_timeout <= timeout_nxt;
      seq_busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      POR_HOLD, ASSERT: state_nxt = cnt == HOLD_LAST ? STAGGER : state;
      STAGGER:          state_nxt = cnt == STAG_LAST ? RUN : STAGGER;
      RUN:              state_nxt = wdt_rst_req ? ASSERT : sys_rst_req ? DRAIN : dbg_rst_req ? CORE_HOLD : RUN;
      DRAIN:            state_nxt = (wdt_rst_req || drain_ack || cnt == DRAIN_LAST) ? ASSERT : DRAIN;
      CORE_HOLD:        state_nxt = wdt_rst_req ? ASSERT : cnt == HOLD_LAST ? RUN : CORE_HOLD;
      default:          state_nxt = POR_HOLD;
    endcase
  end

  // Registered outputs are derived from the state being entered, so they change on the transition edge.
  always_comb begin
    cnt_nxt     = (state_nxt != state || state == RUN) ? '0 : cnt + 1'b1;
    sys_nxt     = state_nxt inside {STAGGER, RUN, DRAIN, CORE_HOLD};
    core_nxt    = state_nxt inside {RUN, DRAIN};
    drain_nxt   = state_nxt == DRAIN;
    busy_nxt    = state_nxt != RUN;
    cause_nxt   = (state_nxt == ASSERT && state != ASSERT && wdt_rst_req) ? 2'b10 :
                  (state == RUN && state_nxt == DRAIN)                   ? 2'b01 :
                  (state == RUN && state_nxt == CORE_HOLD)               ? 2'b11 : rst_cause;
    timeout_nxt = (state == RUN && state_nxt == DRAIN) ? 1'b0 :
                  (state == DRAIN && !wdt_rst_req && !drain_ack && cnt == DRAIN_LAST) ? 1'b1 : drain_timeout;
  end

  assign sys_rst_n_sync  = test_mode ? test_rst_n : sys_q;
  assign core_rst_n_sync = test_mode ? test_rst_n : core_q;
endmodule

// File: tb/tb_ycr1_reset_seq_ctrl.sv
// tb_ycr1_reset_seq_ctrl: directed checks of POR, drain, timeout, debug, watchdog and test-mode paths
module tb_ycr1_reset_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n_mux, test_mode, test_rst_n;
  logic       sys_rst_req, wdt_rst_req, dbg_rst_req, drain_ack;
  logic       drain_req, sys_rst_n_sync, core_rst_n_sync, drain_timeout, seq_busy;
  logic [1:0] rst_cause;
  int         tests = 0;
  int         fails = 0;

  ycr1_reset_seq_ctrl dut (
    .clk(clk), .rst_n_mux(rst_n_mux), .test_mode(test_mode), .test_rst_n(test_rst_n),
    .sys_rst_req(sys_rst_req), .wdt_rst_req(wdt_rst_req), .dbg_rst_req(dbg_rst_req),
    .drain_ack(drain_ack), .drain_req(drain_req), .sys_rst_n_sync(sys_rst_n_sync),
    .core_rst_n_sync(core_rst_n_sync), .rst_cause(rst_cause), .drain_timeout(drain_timeout),
    .seq_busy(seq_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n_mux = 1'b0; test_mode = 1'b0; test_rst_n = 1'b1;
    sys_rst_req = 1'b0; wdt_rst_req = 1'b0; dbg_rst_req = 1'b0; drain_ack = 1'b0;
    edges(3);
    check("rst_sys", sys_rst_n_sync, 0);
    check("rst_core", core_rst_n_sync, 0);
    check("rst_drain", drain_req, 0);
    check("rst_cause", rst_cause, 0);
    check("rst_to", drain_timeout, 0);
    check("rst_busy", seq_busy, 1);
    @(negedge clk) rst_n_mux = 1'b1;
    edges(15); check("por_sys15", sys_rst_n_sync, 0);
    edges(1);  check("por_sys16", sys_rst_n_sync, 1); check("por_core16", core_rst_n_sync, 0);
    edges(3);  check("por_core19", core_rst_n_sync, 0); check("por_busy19", seq_busy, 1);
    edges(1);  check("por_core20", core_rst_n_sync, 1); check("por_busy20", seq_busy, 0);
    check("por_cause", rst_cause, 2'b00);
    // software reset with drain_ack five cycles after drain_req
    sys_rst_req = 1'b1; edges(1); sys_rst_req = 1'b0;
    check("sw_drain", drain_req, 1); check("sw_cause", rst_cause, 2'b01);
    check("sw_sys_hi", sys_rst_n_sync, 1); check("sw_core_hi", core_rst_n_sync, 1); check("sw_busy", seq_busy, 1);
    edges(4); check("sw_drain4", drain_req, 1);
    drain_ack = 1'b1; edges(1); drain_ack = 1'b0;
    check("sw_drain5", drain_req, 0); check("sw_sys_lo", sys_rst_n_sync, 0); check("sw_core_lo", core_rst_n_sync, 0);
    edges(15); check("sw_sys15", sys_rst_n_sync, 0);
    edges(1);  check("sw_sys16", sys_rst_n_sync, 1); check("sw_core16", core_rst_n_sync, 0);
    edges(3);  check("sw_core19", core_rst_n_sync, 0);
    edges(1);  check("sw_core20", core_rst_n_sync, 1); check("sw_busy_end", seq_busy, 0);
    check("sw_cause_end", rst_cause, 2'b01); check("sw_to", drain_timeout, 0);
    // drain timeout
    sys_rst_req = 1'b1; edges(1); sys_rst_req = 1'b0;
    edges(63); check("to_drain63", drain_req, 1); check("to_flag63", drain_timeout, 0);
    edges(1);  check("to_drain64", drain_req, 0); check("to_sys64", sys_rst_n_sync, 0);
    check("to_flag64", drain_timeout, 1); check("to_cause", rst_cause, 2'b01);
    edges(20); check("to_busy_end", seq_busy, 0); check("to_flag_keep", drain_timeout, 1);
    // dbg and sys together: sys wins
    sys_rst_req = 1'b1; dbg_rst_req = 1'b1; edges(1); sys_rst_req = 1'b0; dbg_rst_req = 1'b0;
    check("pri_drain", drain_req, 1); check("pri_cause", rst_cause, 2'b01); check("pri_to_clr", drain_timeout, 0);
    check("pri_core", core_rst_n_sync, 1);
    drain_ack = 1'b1; edges(1); drain_ack = 1'b0;
    edges(20); check("pri_busy_end", seq_busy, 0);
    // debug core-only reset
    dbg_rst_req = 1'b1; edges(1); dbg_rst_req = 1'b0;
    check("dbg_core", core_rst_n_sync, 0); check("dbg_sys", sys_rst_n_sync, 1);
    check("dbg_cause", rst_cause, 2'b11); check("dbg_busy", seq_busy, 1); check("dbg_drain", drain_req, 0);
    edges(15); check("dbg_core15", core_rst_n_sync, 0); check("dbg_sys15", sys_rst_n_sync, 1);
    edges(1);  check("dbg_core16", core_rst_n_sync, 1); check("dbg_busy16", seq_busy, 0);
    // watchdog during drain
    sys_rst_req = 1'b1; edges(1); sys_rst_req = 1'b0;
    edges(2); check("wd_drain", drain_req, 1);
    wdt_rst_req = 1'b1; edges(1); wdt_rst_req = 1'b0;
    check("wd_drain_off", drain_req, 0); check("wd_sys", sys_rst_n_sync, 0);
    check("wd_core", core_rst_n_sync, 0); check("wd_cause", rst_cause, 2'b10); check("wd_to", drain_timeout, 0);
    edges(20); check("wd_busy_end", seq_busy, 0);
    // watchdog during core hold escalates
    dbg_rst_req = 1'b1; edges(1); dbg_rst_req = 1'b0;
    check("wc_cause11", rst_cause, 2'b11);
    edges(3); wdt_rst_req = 1'b1; edges(1); wdt_rst_req = 1'b0;
    check("wc_sys", sys_rst_n_sync, 0); check("wc_cause", rst_cause, 2'b10);
    edges(15); check("wc_sys15", sys_rst_n_sync, 0);
    edges(1);  check("wc_sys16", sys_rst_n_sync, 1);
    edges(4);  check("wc_core", core_rst_n_sync, 1); check("wc_busy", seq_busy, 0);
    // watchdog from RUN, then ignored requests while busy
    wdt_rst_req = 1'b1; edges(1); wdt_rst_req = 1'b0;
    check("wr_sys", sys_rst_n_sync, 0); check("wr_drain", drain_req, 0);
    dbg_rst_req = 1'b1; edges(2); dbg_rst_req = 1'b0;
    check("wr_ign_cause", rst_cause, 2'b10);
    // async reset clears sticky state; test mode overrides outputs
    #2 rst_n_mux = 1'b0; #1;
    check("ar_cause", rst_cause, 0); check("ar_busy", seq_busy, 1); check("ar_sys", sys_rst_n_sync, 0);
    @(negedge clk) rst_n_mux = 1'b1;
    edges(5);
    test_mode = 1'b1; test_rst_n = 1'b1; #1;
    check("tm_sys1", sys_rst_n_sync, 1); check("tm_core1", core_rst_n_sync, 1);
    test_rst_n = 1'b0; #1;
    check("tm_sys0", sys_rst_n_sync, 0); check("tm_core0", core_rst_n_sync, 0);
    test_rst_n = 1'b1;
    edges(3); check("tm_sys_hold", sys_rst_n_sync, 1);
    test_mode = 1'b0; #1;
    check("tm_off_sys", sys_rst_n_sync, 0); check("tm_off_core", core_rst_n_sync, 0);
    edges(7); check("tm_sys15", sys_rst_n_sync, 0);
    edges(1); check("tm_sys16", sys_rst_n_sync, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
